// File: rtl/ghost_motion_ctrl.sv
// ghost_motion_ctrl: per-frame four-ghost position engine with greedy chase through one shared maze query port.
// Define GHOST_SCATTER_EN to add scatter/chase alternation with a forced reversal on every toggle.
module ghost_motion_ctrl #(
   parameter int TILE_COLS = 28,
   parameter int TILE_ROWS = 31
`ifdef GHOST_SCATTER_EN
   ,parameter int SCATTER_FRAMES = 420
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [8:0] pac_x,
   input  logic [8:0] pac_y,
   output logic       wall_req,
   output logic [4:0] wall_col,
   output logic [4:0] wall_row,
   input  logic       wall_ack,
   input  logic       wall_blocked,
   output logic [8:0] x_red,
   output logic [8:0] y_red,
   output logic [8:0] x_pink,
   output logic [8:0] y_pink,
   output logic [8:0] x_blue,
   output logic [8:0] y_blue,
   output logic [8:0] x_orange,
   output logic [8:0] y_orange,
   output logic       busy,
   output logic       overrun
);
   typedef enum logic [2:0] {IDLE, LOAD, QUERY, WAIT, STEP, NEXT} state_t;
   localparam int RW = $clog2(TILE_ROWS);
   localparam logic [8:0] X_MAX = 9'(TILE_COLS * 8 - 1);
   localparam logic [4:0] COL_MAX = 5'(TILE_COLS - 1);
   state_t state, state_nx;
   logic [8:0] gx [4];
   logic [8:0] gy [4];
   logic [1:0] gd [4];
   logic [1:0] cand [4];
   logic [1:0] cand_c [4];
   logic [1:0] raw [4];
   logic [1:0] g, k, nd, rd, ridx, tx, ty, qd;
   logic [8:0] cx, cy, tgt_x, tgt_y;
   logic signed [9:0] dx, dy;
   logic [9:0] ax, ay;
   logic [4:0] col, qcol;
   logic [RW-1:0] row, qrow;
   logic aligned, force_rev;
`ifdef GHOST_SCATTER_EN
   localparam int CW = $clog2(SCATTER_FRAMES);
   logic [CW-1:0] fcnt;
   logic scatter, toggle;
   logic [3:0] rev_pend;
   assign toggle = frame_tick && fcnt == CW'(SCATTER_FRAMES - 1);
   assign force_rev = rev_pend[g];
   assign tgt_x = scatter ? (g[0] ? 9'd0 : 9'd216) : pac_x;
   assign tgt_y = scatter ? (g[1] ? 9'd240 : 9'd0) : pac_y;
   // each ghost consumes its pending reversal at its own LOAD
   always_ff @(posedge clk) begin
      if (!rst) begin
         fcnt <= '0;
         scatter <= 1'b1;
         rev_pend <= '0;
      end else begin
         fcnt <= frame_tick ? (toggle ? '0 : fcnt + 1'b1) : fcnt;
         scatter <= scatter ^ toggle;
         rev_pend <= (rev_pend & ~(state == LOAD ? 4'b1 << g : 4'b0)) | {4{toggle}};
      end
   end
`else
   assign force_rev = 1'b0;
   assign tgt_x = pac_x;
   assign tgt_y = pac_y;
`endif
   assign x_red = gx[0];
   assign y_red = gy[0];
   assign x_pink = gx[1];
   assign y_pink = gy[1];
   assign x_blue = gx[2];
   assign y_blue = gy[2];
   assign x_orange = gx[3];
   assign y_orange = gy[3];
   assign aligned = ~|{gx[g][2:0], gy[g][2:0]};
   // greedy ordering; the reverse direction is compacted to the last slot
   always_comb begin
      dx = $signed({1'b0, tgt_x}) - $signed({1'b0, gx[g]});
      dy = $signed({1'b0, tgt_y}) - $signed({1'b0, gy[g]});
      ax = dx[9] ? -dx : dx;
      ay = dy[9] ? -dy : dy;
      tx = dx[9] ? 2'd1 : 2'd3;
      ty = dy[9] ? 2'd0 : 2'd2;
      raw[0] = ax >= ay ? tx : ty;
      raw[1] = ax >= ay ? ty : tx;
      raw[2] = raw[1] ^ 2'd2;
      raw[3] = raw[0] ^ 2'd2;
      rd = gd[g] ^ 2'd2;
      ridx = raw[0] == rd ? 2'd0 : raw[1] == rd ? 2'd1 : raw[2] == rd ? 2'd2 : 2'd3;
      cand_c[0] = ridx == 2'd0 ? raw[1] : raw[0];
      cand_c[1] = ridx <= 2'd1 ? raw[2] : raw[1];
      cand_c[2] = ridx <= 2'd2 ? raw[3] : raw[2];
      cand_c[3] = rd;
   end
   always_comb begin
      qd = cand[k];
      col = cx[7:3];
      row = cy[RW+2:3];
      qcol = qd == 2'd1 ? (col == 5'd0 ? COL_MAX : col - 5'd1) :
             qd == 2'd3 ? (col == COL_MAX ? 5'd0 : col + 5'd1) : col;
      qrow = qd == 2'd0 ? row - 1'b1 : qd == 2'd2 ? row + 1'b1 : row;
   end
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = frame_tick ? LOAD : IDLE;
         LOAD:    state_nx = force_rev || !aligned ? STEP : QUERY;
         QUERY:   state_nx = WAIT;
         WAIT:    state_nx = !wall_ack ? WAIT : !wall_blocked ? STEP : k == 2'd3 ? NEXT : QUERY;
         STEP:    state_nx = NEXT;
         NEXT:    state_nx = g == 2'd3 ? IDLE : LOAD;
         default: state_nx = IDLE;
      endcase
   end
   always_comb busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (!rst) begin
         gx[0] <= 9'd104;
         gy[0] <= 9'd88;
         gx[1] <= 9'd104;
         gy[1] <= 9'd112;
         gx[2] <= 9'd88;
         gy[2] <= 9'd112;
         gx[3] <= 9'd120;
         gy[3] <= 9'd112;
         for (int i = 0; i < 4; i++) gd[i] <= 2'd1;
         g <= '0;
         k <= '0;
         wall_req <= 1'b0;
         wall_col <= '0;
         wall_row <= '0;
         overrun <= 1'b0;
      end else begin
         overrun <= overrun | (frame_tick && state != IDLE);
         if (state == IDLE) g <= '0;
         if (state == NEXT) g <= g + 2'd1;
         if (state == LOAD) begin
            cx <= gx[g];
            cy <= gy[g];
            nd <= force_rev ? gd[g] ^ 2'd2 : gd[g];
            k <= '0;
            cand <= cand_c;
         end
         if (state == QUERY) begin
            wall_req <= 1'b1;
            wall_col <= qcol;
            wall_row <= 5'(qrow);
         end
         if (state == WAIT && wall_ack) begin
            wall_req <= 1'b0;
            if (!wall_blocked) nd <= cand[k];
            else k <= k + 2'd1;
         end
         if (state == STEP) begin
            gx[g] <= nd == 2'd1 ? (cx == 9'd0 ? X_MAX : cx - 9'd1) :
                     nd == 2'd3 ? (cx == X_MAX ? 9'd0 : cx + 9'd1) : cx;
            gy[g] <= nd == 2'd0 ? cy - 9'd1 : nd == 2'd2 ? cy + 9'd1 : cy;
            gd[g] <= nd;
         end
      end
   end
endmodule
